// File: rtl/shift_reg_universal_if.sv
// Bus bundle for shift_reg_universal: control/data inputs plus register, serial and counter outputs.
interface shift_reg_universal_if #(
  parameter int WIDTH = 8,
  parameter int STEP  = 1
) ();
  localparam int NSTEP = WIDTH / STEP;
  localparam int CNT_W = (NSTEP > 1) ? $clog2(NSTEP) : 1;

  logic             en;
  logic [2:0]       mode;
  logic [WIDTH-1:0] d;
  logic [STEP-1:0]  sin_l;
  logic [STEP-1:0]  sin_r;
  logic [WIDTH-1:0] q;
  logic [STEP-1:0]  sout_l;
  logic [STEP-1:0]  sout_r;
  logic [CNT_W-1:0] shift_cnt;
  logic             word_done;

  modport master (
    output en, mode, d, sin_l, sin_r,
    input  q, sout_l, sout_r, shift_cnt, word_done
  );

  modport slave (
    input  en, mode, d, sin_l, sin_r,
    output q, sout_l, sout_r, shift_cnt, word_done
  );
endinterface

// File: rtl/shift_reg_universal.sv
// Universal shift register: hold, shift/rotate L/R, arithmetic shift R, load, clear,
// STEP bits per operation, with a word-completion counter for SerDes framing.
module shift_reg_universal #(
  parameter int WIDTH = 8,
  parameter int STEP  = 1
) (
  input  logic                  clk,
  input  logic                  reset_n,
  shift_reg_universal_if.slave  bus
);
  localparam int NSTEP = WIDTH / STEP;
  localparam int CNT_W = (NSTEP > 1) ? $clog2(NSTEP) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(NSTEP - 1);

  generate
    if (WIDTH < 2 || STEP < 1 || STEP >= WIDTH || (WIDTH % STEP) != 0) begin : g_bad_params
      $error("shift_reg_universal: illegal WIDTH=%0d / STEP=%0d", WIDTH, STEP);
    end
  endgenerate

  typedef enum logic [2:0] {
    MODE_HOLD  = 3'b000,
    MODE_SHL   = 3'b001,
    MODE_SHR   = 3'b010,
    MODE_ROL   = 3'b011,
    MODE_ROR   = 3'b100,
    MODE_LOAD  = 3'b101,
    MODE_CLEAR = 3'b110,
    MODE_ASR   = 3'b111
  } mode_t;

  mode_t            mode;
  logic [WIDTH-1:0] q_r;
  logic [WIDTH-1:0] q_next;
  logic [CNT_W-1:0] cnt_r;
  logic             done_r;
  logic             shift_op;
  logic             clr_cnt;
  logic             wrap;

  assign mode = mode_t'(bus.mode);

  always_comb begin
    q_next   = q_r;
    shift_op = 1'b0;
    clr_cnt  = 1'b0;
    case (mode)
      MODE_HOLD:  q_next = q_r;
      MODE_SHL: begin
        q_next   = {q_r[WIDTH-1-STEP:0], bus.sin_l};
        shift_op = 1'b1;
      end
      MODE_SHR: begin
        q_next   = {bus.sin_r, q_r[WIDTH-1:STEP]};
        shift_op = 1'b1;
      end
      MODE_ROL: begin
        q_next   = {q_r[WIDTH-1-STEP:0], q_r[WIDTH-1 -: STEP]};
        shift_op = 1'b1;
      end
      MODE_ROR: begin
        q_next   = {q_r[STEP-1:0], q_r[WIDTH-1:STEP]};
        shift_op = 1'b1;
      end
      MODE_LOAD: begin
        q_next  = bus.d;
        clr_cnt = 1'b1;
      end
      MODE_CLEAR: begin
        q_next  = '0;
        clr_cnt = 1'b1;
      end
      MODE_ASR: begin
        q_next   = {{STEP{q_r[WIDTH-1]}}, q_r[WIDTH-1:STEP]};
        shift_op = 1'b1;
      end
      default: q_next = q_r;
    endcase
  end

  assign wrap = shift_op && (cnt_r == LAST);

  // word_done is updated regardless of en so the pulse never outlives one cycle
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      q_r    <= '0;
      cnt_r  <= '0;
      done_r <= 1'b0;
    end else begin
      done_r <= bus.en & wrap;
      if (bus.en) begin
        q_r <= q_next;
        if (clr_cnt || wrap) begin
          cnt_r <= '0;
        end else if (shift_op) begin
          cnt_r <= cnt_r + CNT_W'(1);
        end
      end
    end
  end

  assign bus.q         = q_r;
  assign bus.sout_l    = q_r[WIDTH-1 -: STEP];
  assign bus.sout_r    = q_r[STEP-1:0];
  assign bus.shift_cnt = cnt_r;
  assign bus.word_done = done_r;
endmodule

// File: tb/tb_shift_reg_universal.sv
// Self-checking bench for shift_reg_universal: directed scenarios plus randomized traffic
// on an 8/1 and a 16/4 instance, compared against an arithmetic reference model.
module tb_shift_reg_universal;
  logic clk;
  logic reset_n;
  int   checks;
  int   failures;

  // reference model state
  int unsigned mq8, mqw;
  int          mcnt8, mcntw;
  logic        mdone8, mdonew;

  shift_reg_universal_if #(.WIDTH(8),  .STEP(1)) b8 ();
  shift_reg_universal_if #(.WIDTH(16), .STEP(4)) bw ();

  shift_reg_universal #(.WIDTH(8), .STEP(1)) u8 (
    .clk(clk), .reset_n(reset_n), .bus(b8)
  );
  shift_reg_universal #(.WIDTH(16), .STEP(4)) uw (
    .clk(clk), .reset_n(reset_n), .bus(bw)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic is_shift(input logic [2:0] m);
    return (m inside {3'd1, 3'd2, 3'd3, 3'd4, 3'd7});
  endfunction

  // next register value from the operation definitions using plain integer arithmetic
  function automatic int unsigned model_next(input int unsigned q, input int w, input int n,
                                             input logic [2:0] m, input int unsigned dd,
                                             input int unsigned sl, input int unsigned sr);
    int unsigned mask = (32'd1 << w) - 32'd1;
    int unsigned lo   = (32'd1 << n) - 32'd1;
    int unsigned top  = mask & ~(mask >> n);
    case (m)
      3'd0: return q;
      3'd1: return ((q << n) | (sl & lo)) & mask;
      3'd2: return ((sr & lo) << (w - n)) | (q >> n);
      3'd3: return ((q << n) | (q >> (w - n))) & mask;
      3'd4: return ((q & lo) << (w - n)) | (q >> n);
      3'd5: return dd & mask;
      3'd6: return 0;
      default: return (q >> n) | ((((q >> (w - 1)) & 1) != 0) ? top : 32'd0);
    endcase
  endfunction

  task automatic reset_models();
    mq8 = 0; mcnt8 = 0; mdone8 = 1'b0;
    mqw = 0; mcntw = 0; mdonew = 1'b0;
  endtask

  // advance one clock; models follow the inputs presented at the edge
  task automatic step();
    @(posedge clk);
    if (reset_n) begin
      mdone8 = b8.en && is_shift(b8.mode) && (mcnt8 == 7);
      if (b8.en) begin
        mq8 = model_next(mq8, 8, 1, b8.mode, b8.d, b8.sin_l, b8.sin_r);
        if (is_shift(b8.mode))                   mcnt8 = (mcnt8 + 1) % 8;
        else if (b8.mode inside {3'd5, 3'd6})    mcnt8 = 0;
      end
      mdonew = bw.en && is_shift(bw.mode) && (mcntw == 3);
      if (bw.en) begin
        mqw = model_next(mqw, 16, 4, bw.mode, bw.d, bw.sin_l, bw.sin_r);
        if (is_shift(bw.mode))                   mcntw = (mcntw + 1) % 4;
        else if (bw.mode inside {3'd5, 3'd6})    mcntw = 0;
      end
    end
    #1;
  endtask

  task automatic drive8(input logic e, input logic [2:0] m, input logic [7:0] dd,
                        input logic sl, input logic sr);
    b8.en = e; b8.mode = m; b8.d = dd; b8.sin_l = sl; b8.sin_r = sr;
  endtask

  task automatic drivew(input logic e, input logic [2:0] m, input logic [15:0] dd,
                        input logic [3:0] sl, input logic [3:0] sr);
    bw.en = e; bw.mode = m; bw.d = dd; bw.sin_l = sl; bw.sin_r = sr;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    drive8(1'b0, 3'd0, 8'h00, 1'b0, 1'b0);
    drivew(1'b0, 3'd0, 16'h0000, 4'h0, 4'h0);
    reset_models();
    #2;
    checks++;
    if ({b8.q, b8.shift_cnt, b8.word_done} !== 12'h000) begin
      failures++;
      $display("FAIL reset_initial: got q=%h cnt=%0d done=%b, want 00/0/0", b8.q, b8.shift_cnt, b8.word_done);
    end
    @(posedge clk); #1;
    reset_n = 1'b1;
    drive8(1'b1, 3'd5, 8'hA5, 1'b0, 1'b0);
    step();
    drive8(1'b1, 3'd1, 8'h00, 1'b1, 1'b0);
    for (int i = 0; i < 8; i++) step();
    checks++;
    if (b8.word_done !== 1'b1 || b8.q !== 8'hFF) begin
      failures++;
      $display("FAIL reset_preamble: got q=%h done=%b, want ff/1", b8.q, b8.word_done);
    end
    drive8(1'b1, 3'd1, 8'h00, 1'b0, 1'b0);
    step(); step(); step();
    #2;
    reset_n = 1'b0;
    reset_models();
    #1;
    checks++;
    if ({b8.q, b8.shift_cnt, b8.word_done} !== 12'h000) begin
      failures++;
      $display("FAIL reset_async_mid_shift: got q=%h cnt=%0d done=%b, want 00/0/0", b8.q, b8.shift_cnt, b8.word_done);
    end
    @(posedge clk); #1;
    checks++;
    if (b8.q !== 8'h00) begin
      failures++;
      $display("FAIL reset_held_over_edge: got q=%h, want 00", b8.q);
    end
    reset_n = 1'b1;
  endtask

  task automatic test_shift_basic();
    drive8(1'b1, 3'd5, 8'hA5, 1'b0, 1'b0);
    step();
    drive8(1'b1, 3'd1, 8'h00, 1'b1, 1'b0);
    step();
    checks++;
    if (b8.q !== 8'h4B || b8.sout_l !== 1'b0 || b8.sout_r !== 1'b1) begin
      failures++;
      $display("FAIL shl: got q=%h sout_l=%b sout_r=%b, want 4b/0/1", b8.q, b8.sout_l, b8.sout_r);
    end
    drive8(1'b1, 3'd2, 8'h00, 1'b0, 1'b1);
    step();
    checks++;
    if (b8.q !== 8'hA5 || b8.shift_cnt !== 3'd2) begin
      failures++;
      $display("FAIL shr: got q=%h cnt=%0d, want a5/2", b8.q, b8.shift_cnt);
    end
  endtask

  task automatic test_rotate_asr();
    logic [7:0] exp_q [4];
    exp_q[0] = 8'hC0; exp_q[1] = 8'h81; exp_q[2] = 8'hC0; exp_q[3] = 8'hE0;
    drive8(1'b1, 3'd5, 8'h81, 1'b0, 1'b0);
    step();
    for (int i = 0; i < 4; i++) begin
      if (i == 2) begin
        drive8(1'b1, 3'd5, 8'h80, 1'b0, 1'b0);
        step();
      end
      // sin values are set opposite to what the op must produce, to expose leakage
      case (i)
        0:       drive8(1'b1, 3'd4, 8'h00, 1'b0, 1'b0);
        1:       drive8(1'b1, 3'd3, 8'h00, 1'b0, 1'b0);
        default: drive8(1'b1, 3'd7, 8'h00, 1'b0, 1'b0);
      endcase
      step();
      checks++;
      if (b8.q !== exp_q[i]) begin
        failures++;
        $display("FAIL rot_asr[%0d]: got q=%h, want %h", i, b8.q, exp_q[i]);
      end
    end
  endtask

  task automatic test_word_done();
    drive8(1'b1, 3'd5, 8'h3C, 1'b0, 1'b0);
    step();
    drive8(1'b1, 3'd1, 8'h00, 1'b0, 1'b0);
    for (int i = 1; i <= 8; i++) begin
      step();
      checks++;
      if (b8.shift_cnt !== 3'(i % 8) || b8.word_done !== (i == 8)) begin
        failures++;
        $display("FAIL word_count[%0d]: got cnt=%0d done=%b, want %0d/%b",
                 i, b8.shift_cnt, b8.word_done, i % 8, (i == 8));
      end
    end
    drive8(1'b1, 3'd0, 8'h00, 1'b0, 1'b0);
    step();
    checks++;
    if (b8.word_done !== 1'b0 || b8.shift_cnt !== 3'd0) begin
      failures++;
      $display("FAIL word_pulse_width: got cnt=%0d done=%b, want 0/0", b8.shift_cnt, b8.word_done);
    end
    drive8(1'b1, 3'd5, 8'h11, 1'b0, 1'b0);
    step();
    drive8(1'b1, 3'd1, 8'h00, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) step();
    drive8(1'b1, 3'd5, 8'h22, 1'b0, 1'b0);
    step();
    checks++;
    if (b8.shift_cnt !== 3'd0 || b8.word_done !== 1'b0 || b8.q !== 8'h22) begin
      failures++;
      $display("FAIL load_mid_word: got q=%h cnt=%0d done=%b, want 22/0/0", b8.q, b8.shift_cnt, b8.word_done);
    end
    drive8(1'b1, 3'd2, 8'h00, 1'b0, 1'b0);
    for (int i = 0; i < 7; i++) step();
    checks++;
    if (b8.shift_cnt !== 3'd7 || b8.word_done !== 1'b0) begin
      failures++;
      $display("FAIL restart_count: got cnt=%0d done=%b, want 7/0", b8.shift_cnt, b8.word_done);
    end
  endtask

  task automatic test_enable_clear();
    logic [7:0] frozen_q;
    drive8(1'b1, 3'd5, 8'h3C, 1'b0, 1'b0);
    step();
    drive8(1'b1, 3'd1, 8'h00, 1'b1, 1'b0);
    step(); step();
    frozen_q = b8.q;
    drive8(1'b0, 3'd1, 8'hFF, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (b8.q !== frozen_q || b8.shift_cnt !== 3'd2 || b8.q !== mq8[7:0]) begin
        failures++;
        $display("FAIL en_freeze[%0d]: got q=%h cnt=%0d, want %h/2", i, b8.q, b8.shift_cnt, frozen_q);
      end
    end
    drive8(1'b1, 3'd1, 8'h00, 1'b0, 1'b0);
    for (int i = 0; i < 6; i++) step();
    drive8(1'b0, 3'd1, 8'h00, 1'b0, 1'b0);
    step();
    checks++;
    if (b8.word_done !== 1'b0 || b8.shift_cnt !== 3'd0) begin
      failures++;
      $display("FAIL en_low_clears_pulse: got cnt=%0d done=%b, want 0/0", b8.shift_cnt, b8.word_done);
    end
    drive8(1'b1, 3'd5, 8'hFF, 1'b0, 1'b0);
    step();
    drive8(1'b1, 3'd6, 8'hFF, 1'b1, 1'b1);
    step();
    checks++;
    if (b8.q !== 8'h00 || b8.shift_cnt !== 3'd0) begin
      failures++;
      $display("FAIL clear: got q=%h cnt=%0d, want 00/0", b8.q, b8.shift_cnt);
    end
  endtask

  task automatic test_random8();
    for (int i = 0; i < 300; i++) begin
      drive8($urandom_range(0, 7) != 0, 3'($urandom_range(0, 7)), 8'($urandom),
             1'($urandom), 1'($urandom));
      step();
      checks++;
      if (b8.q !== mq8[7:0] || b8.shift_cnt !== mcnt8[2:0] || b8.word_done !== mdone8 ||
          b8.sout_l !== mq8[7] || b8.sout_r !== mq8[0]) begin
        failures++;
        $display("FAIL random8[%0d]: got q=%h cnt=%0d done=%b sl=%b sr=%b, want q=%h cnt=%0d done=%b",
                 i, b8.q, b8.shift_cnt, b8.word_done, b8.sout_l, b8.sout_r, mq8[7:0], mcnt8, mdone8);
      end
    end
    drive8(1'b0, 3'd0, 8'h00, 1'b0, 1'b0);
  endtask

  task automatic test_wide();
    logic [15:0] exp_q [4];
    exp_q[0] = 16'h234F; exp_q[1] = 16'h34FF; exp_q[2] = 16'h4FFF; exp_q[3] = 16'hFFFF;
    drivew(1'b1, 3'd5, 16'h1234, 4'h0, 4'h0);
    step();
    drivew(1'b1, 3'd1, 16'h0000, 4'hF, 4'h0);
    for (int i = 0; i < 4; i++) begin
      step();
      checks++;
      if (bw.q !== exp_q[i] || bw.shift_cnt !== 2'((i + 1) % 4) || bw.word_done !== (i == 3)) begin
        failures++;
        $display("FAIL wide_shl[%0d]: got q=%h cnt=%0d done=%b, want %h/%0d/%b",
                 i, bw.q, bw.shift_cnt, bw.word_done, exp_q[i], (i + 1) % 4, (i == 3));
      end
    end
    checks++;
    if (bw.sout_l !== 4'hF || bw.sout_r !== 4'hF) begin
      failures++;
      $display("FAIL wide_sout: got sl=%h sr=%h, want f/f", bw.sout_l, bw.sout_r);
    end
    for (int i = 0; i < 150; i++) begin
      drivew($urandom_range(0, 7) != 0, 3'($urandom_range(0, 7)), 16'($urandom),
             4'($urandom), 4'($urandom));
      step();
      checks++;
      if (bw.q !== mqw[15:0] || bw.shift_cnt !== mcntw[1:0] || bw.word_done !== mdonew ||
          bw.sout_l !== mqw[15:12] || bw.sout_r !== mqw[3:0]) begin
        failures++;
        $display("FAIL random16[%0d]: got q=%h cnt=%0d done=%b, want q=%h cnt=%0d done=%b",
                 i, bw.q, bw.shift_cnt, bw.word_done, mqw[15:0], mcntw, mdonew);
      end
    end
    drivew(1'b0, 3'd0, 16'h0000, 4'h0, 4'h0);
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    test_reset();
    test_shift_basic();
    test_rotate_asr();
    test_word_done();
    test_enable_clear();
    test_random8();
    test_wide();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
